// File: rtl/aes_pkg.sv
// Shared AES types, round constants and GF(2^8) helpers.
// Used by the key schedule blocks and the S-box.
package aes_pkg;

   typedef logic [127:0] aes_block_t;
   typedef logic [31:0]  aes_word_t;

   typedef enum logic [1:0] {IDLE, RUN, DONE} ks_state_e;

   localparam logic [7:0] RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Step Rcon back one round: undo xtime, including the 0x80 -> 0x1b wrap.
   function automatic logic [7:0] inv_xtime(input logic [7:0] r);
      return (r == 8'h1b) ? 8'h80 : {1'b0, r[7:1]};
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                         input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, computed as GF(2^8) inverse plus affine map.
// The inverse is x^254, so zero maps to zero as the cipher requires.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] a_i,
   output logic [7:0] s_o
);

   logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

   assign x2   = gf_mul(a_i, a_i);
   assign x3   = gf_mul(x2, a_i);
   assign x6   = gf_mul(x3, x3);
   assign x12  = gf_mul(x6, x6);
   assign x15  = gf_mul(x12, x3);
   assign x30  = gf_mul(x15, x15);
   assign x60  = gf_mul(x30, x30);
   assign x120 = gf_mul(x60, x60);
   assign x240 = gf_mul(x120, x120);
   assign x252 = gf_mul(x240, x12);
   assign inv  = gf_mul(x252, x2);

   assign s_o = inv
              ^ {inv[6:0], inv[7]}
              ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]}
              ^ 8'h63;

endmodule

// File: rtl/aes_inv_keyexp.sv
// Reverse AES-128 key schedule: walks from round NR down to round 0,
// one round per clock, streaming each round key and holding the cipher key.
module aes_inv_keyexp
   import aes_pkg::*;
#(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] in,
   output logic         finish,
   output logic [127:0] key,
   output logic [127:0] rk,
   output logic [3:0]   rk_round,
   output logic         rk_valid
);

   localparam logic [3:0] NR4 = 4'(NR);

   ks_state_e  state_q;
   aes_block_t rk_q, rk_d, key_q;
   logic [3:0] rnd_q, rnd_d;
   logic [7:0] rcon_q;
   logic       vld_q, fin_q;

   aes_word_t w0, w1, w2, w3;
   aes_word_t n0, n1, n2, n3;
   aes_word_t rot, sub;

   assign w0 = rk_q[31:0];
   assign w1 = rk_q[63:32];
   assign w2 = rk_q[95:64];
   assign w3 = rk_q[127:96];

   assign n3 = w3 ^ w2;
   assign n2 = w2 ^ w1;
   assign n1 = w1 ^ w0;

   // Byte 0 of the rotated word is byte 1 of n3 (little-endian byte order).
   assign rot = {n3[7:0], n3[31:24], n3[23:16], n3[15:8]};

   for (genvar i = 0; i < 4; i++) begin : g_sub
      aes_sbox u_sbox (
         .a_i (rot[8*i +: 8]),
         .s_o (sub[8*i +: 8])
      );
   end

   assign n0    = w0 ^ sub ^ {24'h0, rcon_q};
   assign rk_d  = {n3, n2, n1, n0};
   assign rnd_d = rnd_q - 4'd1;

   // Control FSM with all outputs registered; start low aborts or releases.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         rk_q    <= '0;
         rnd_q   <= '0;
         rcon_q  <= '0;
         vld_q   <= 1'b0;
         fin_q   <= 1'b0;
         key_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  rk_q    <= in;
                  rnd_q   <= NR4;
                  rcon_q  <= RCON[NR];
                  vld_q   <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (!start) begin
                  vld_q   <= 1'b0;
                  fin_q   <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  rk_q   <= rk_d;
                  rnd_q  <= rnd_d;
                  rcon_q <= inv_xtime(rcon_q);
                  if (rnd_d == 4'd0) begin
                     key_q   <= rk_d;
                     fin_q   <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               vld_q <= 1'b0;
               if (!start) begin
                  fin_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign finish   = fin_q;
   assign key      = key_q;
   assign rk       = rk_q;
   assign rk_round = rnd_q;
   assign rk_valid = vld_q;

endmodule

// File: tb/tb_aes_inv_keyexp.sv
// Directed bench for the reverse AES-128 key schedule.
// Uses FIPS-197 key expansion vectors for NR=10 and NR=1 builds.
module tb_aes_inv_keyexp;

   logic         clk = 1'b0;
   logic         rst;
   logic         start, start1;
   logic [127:0] in, in1;
   logic         finish, finish1;
   logic [127:0] key, key1, rk, rk1;
   logic [3:0]   rk_round, rk_round1;
   logic         rk_valid, rk_valid1;

   localparam logic [127:0] K10 = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
   localparam logic [127:0] K9  = 128'h6e005c574129d12821dcfa19f36677ac;
   localparam logic [127:0] K1  = 128'h05766c2a3939a323b12c548817fefaa0;
   localparam logic [127:0] K0  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   aes_inv_keyexp #(.NR(10)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in       (in),
      .finish   (finish),
      .key      (key),
      .rk       (rk),
      .rk_round (rk_round),
      .rk_valid (rk_valid)
   );

   aes_inv_keyexp #(.NR(1)) dut1 (
      .clk      (clk),
      .rst      (rst),
      .start    (start1),
      .in       (in1),
      .finish   (finish1),
      .key      (key1),
      .rk       (rk1),
      .rk_round (rk_round1),
      .rk_valid (rk_valid1)
   );

   task automatic chk(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Load and step a full NR=10 run, checking the trace on every cycle.
   task automatic full_run(input string tag);
      start = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         tick();
         chk({tag, " round"}, 128'(rk_round), 128'(10 - k));
         chk({tag, " valid"}, 128'(rk_valid), 128'd1);
         chk({tag, " finish"}, 128'(finish), 128'(k == 10));
         if (k == 1) chk({tag, " rk9"}, rk, K9);
         if (k == 9) chk({tag, " rk1"}, rk, K1);
      end
      chk({tag, " key"}, key, K0);
   endtask

   initial begin
      rst    = 1'b0;
      start  = 1'b0;
      start1 = 1'b0;
      in     = K10;
      in1    = K1;
      #12;
      chk("rst finish", 128'(finish), 128'd0);
      chk("rst key", key, 128'd0);
      chk("rst rk", rk, 128'd0);
      chk("rst round", 128'(rk_round), 128'd0);
      chk("rst valid", 128'(rk_valid), 128'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      full_run("run1");
      in = ~K10;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold finish", 128'(finish), 128'd1);
         chk("hold key", key, K0);
         chk("hold valid", 128'(rk_valid), 128'd0);
      end
      in = K10;
      start = 1'b0;
      tick();
      chk("release finish", 128'(finish), 128'd0);
      chk("release key", key, K0);

      full_run("run2");
      start = 1'b0;
      tick();

      start = 1'b1;
      for (int k = 0; k <= 6; k++) tick();
      chk("abort round", 128'(rk_round), 128'd4);
      start = 1'b0;
      tick();
      chk("abort valid", 128'(rk_valid), 128'd0);
      chk("abort finish", 128'(finish), 128'd0);
      chk("abort key", key, K0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("abort idle fin", 128'(finish), 128'd0);
      end

      start = 1'b1;
      for (int k = 0; k <= 3; k++) tick();
      #2;
      rst   = 1'b0;
      start = 1'b0;
      #1;
      chk("arst finish", 128'(finish), 128'd0);
      chk("arst key", key, 128'd0);
      chk("arst rk", rk, 128'd0);
      chk("arst round", 128'(rk_round), 128'd0);
      chk("arst valid", 128'(rk_valid), 128'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      full_run("run3");
      start = 1'b0;
      tick();

      start1 = 1'b1;
      tick();
      chk("nr1 load round", 128'(rk_round1), 128'd1);
      chk("nr1 load finish", 128'(finish1), 128'd0);
      tick();
      chk("nr1 finish", 128'(finish1), 128'd1);
      chk("nr1 key", key1, K0);
      chk("nr1 round", 128'(rk_round1), 128'd0);
      start1 = 1'b0;
      tick();
      chk("nr1 release", 128'(finish1), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/aes_inv_keyexp.md
Name: aes_inv_keyexp

Overview:
- Reverse AES-128 key schedule for the decryption path; the counterpart of the forward round-key generator `newkey`.
- Takes the last round key and steps backwards one round per clock.
- Streams every round key, from round NR down to round 0, to the inverse-cipher datapath.
- Finishes holding the original cipher key.
- Uses the same level-start / held-finish handshake as `newkey`.

Parameters:
- NR, 10, index of the round key presented on `in`. Legal range 1..10. The block performs NR backward steps.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  level request. Rising while idle launches a run; held high through finish; deassert to release.
- in  input  128  round-NR key. Byte 0 in [7:0], byte 15 in [127:120].
- finish  output  1  high while the result is valid and start is still high.
- key  output  128  recovered cipher key (round 0). Valid while finish is high.
- rk  output  128  current round key, same byte order as `in`.
- rk_round  output  4  round index of `rk`.
- rk_valid  output  1  `rk`/`rk_round` valid this cycle.

Behaviour:
- Reset values: all outputs 0, state IDLE.
- States:
  - IDLE: finish=0, rk_valid=0. At the first posedge with start=1: rk<=in, rk_round<=NR, rk_valid<=1, rcon<=RCON[NR], go to RUN.
  - RUN: each posedge with start=1:
    - If rk_round>0: step rk to round rk_round-1, decrement rk_round, keep rk_valid=1. rcon<=inv_xtime(rcon), where inv_xtime = 8'h80 if rcon==8'h1b, else rcon>>1.
    - The step that makes rk_round=0 also loads key<=new rk, sets finish<=1 and moves to DONE.
    - Latency: finish rises NR posedges after the load edge. rk_valid is high for NR+1 consecutive cycles.
  - DONE: finish=1, key held, rk_valid=0. Leave when start=0: next posedge gives finish=0 and IDLE.
- Step arithmetic. w0..w3 are 32-bit words, w0=rk[31:0], w3=rk[127:96]. Primed words are the step results:
  - w3'=w3^w2
  - w2'=w2^w1
  - w1'=w1^w0
  - w0'=w0^SubWord(RotWord(w3'))^{24'h0,rcon}, with Rcon placed in byte 0 of the word.
  - RotWord in this byte order: {b0,b3,b2,b1}, where bN is byte N of w3'.
  - SubWord applies the forward S-box to each byte.
- Boundary conditions:
  - start dropped during RUN: abort. Next posedge gives IDLE, rk_valid=0, finish=0, key unchanged.
  - start re-raised in the same cycle DONE exits: ignored. A new run needs one IDLE cycle with start=0.
  - `in` is sampled only at the load edge. Later changes have no effect.
  - rst low at any time: immediate return to IDLE with all outputs 0, including mid-RUN.
  - NR=1: one step. finish rises one edge after load.

Decomposition:
- Package `aes_pkg`:
  - `aes_block_t` (logic [127:0]) and `aes_word_t` (logic [31:0]).
  - `RCON[1:10]` constant table: 01,02,04,08,10,20,40,80,1b,36.
  - Function `inv_xtime`.
  - State enum {IDLE, RUN, DONE}.
- Sub-module `aes_sbox`: combinational 8-bit forward S-box, instantiated 4× for SubWord. Shared with the forward key generator.

Test Plan:
- FIPS-197 key, NR=10:
  - in=128'ha60c63b6c80c3fe18925eec9a8f914d0, start held high.
  - key=128'h3c4fcf098815f7aba6d2ae2816157e2b with finish=1 exactly 10 edges after load.
  - Check the rk_round trace 10..0.
- Intermediate round keys in the same run:
  - rk_round=9: rk=128'h6e005c574129d12821dcfa19f36677ac.
  - rk_round=1: rk=128'h05766c2a3939a323b12c548817fefaa0.
- Handshake hold and release:
  - Keep start=1 for 5 cycles after finish: key stable, finish stays 1, rk_valid=0.
  - Drop start: finish=0 after one edge.
  - Re-raise start with the same `in`: identical result.
- Abort: drop start at rk_round=4. Next edge: IDLE, rk_valid=0, finish never asserts, key keeps its previous value.
- Async reset: pull rst low mid-RUN between clock edges. All outputs are 0 immediately. After release, a fresh run produces the correct key.
- NR=1 build:
  - in=128'h05766c2a3939a323b12c548817fefaa0.
  - key=128'h3c4fcf098815f7aba6d2ae2816157e2b one edge after load.
